sensor_node_responder: RTL and testbench

- Sensor-side end of the shared half-duplex UART sensor bus; the bus arbiter is the initiator.
- Receives request bytes over the UART link; when a READ request carries this node's address, sends back one data byte followed by one CRC-8 byte.
- Drives the shared line only while responding and releases it otherwise.
- Instantiates the existing uart_rx and uart_tx modules; adds the request decoder, sensor snapshot, CRC generator and response FSM.

---
 rtl/sensor_bus_pkg.sv | 32 +++
 rtl/sensor_node_responder_if.sv | 9 +
 rtl/sensor_node_responder_crc8_gen.sv | 10 +
 rtl/uart_rx.sv | 62 ++++++
 rtl/uart_tx.sv | 53 +++++
 rtl/sensor_node_responder.sv | 157 +++++++++++++++
 tb/tb_sensor_node_responder.sv | 277 +++++++++++++++++++++++++++
 7 files changed

// File: rtl/sensor_bus_pkg.sv
// Shared sensor-bus definitions: request command/address codes, CRC-8
// parameters, responder FSM state encoding and the crc8 helper that the
// arbiter-side checker also uses.
package sensor_bus_pkg;

  localparam logic [4:0] CMD_READ       = 5'b00001;
  localparam logic [2:0] ADDR_COLLISION = 3'd0;
  localparam logic [7:0] CRC8_POLY      = 8'h07;
  localparam logic [7:0] CRC8_INIT      = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_GUARD     = 3'd2,
    ST_SEND_DATA = 3'd3,
    ST_WAIT_DATA = 3'd4,
    ST_SEND_CRC  = 3'd5,
    ST_WAIT_CRC  = 3'd6,
    ST_DONE      = 3'd7
  } resp_state_t;

  // MSB-first, non-reflected, no final XOR, over a single byte
  function automatic logic [7:0] crc8(input logic [7:0] data);
    logic [7:0] crc;
    crc = CRC8_INIT ^ data;
    for (int i = 0; i < 8; i++) begin
      crc = crc[7] ? ({crc[6:0], 1'b0} ^ CRC8_POLY) : {crc[6:0], 1'b0};
    end
    return crc;
  endfunction

endpackage

// File: rtl/sensor_node_responder_if.sv
// Serial bus pins between the arbiter side (master) and a sensor node (slave).
interface sensor_node_responder_if;
  logic rx;
  logic tx;
  logic tx_oe;

  modport master (output rx, input tx, input tx_oe);
  modport slave  (input rx, output tx, output tx_oe);
endinterface

// File: rtl/sensor_node_responder_crc8_gen.sv
// Combinational CRC-8 of one byte (the response checksum).
module crc8_gen
  import sensor_bus_pkg::*;
(
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);
  // Single-byte CRC from the shared package helper
  assign crc_out = crc8(data_in);
endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first. done_rx pulses for one cycle when a valid
// stop bit is sampled; data_rx holds the byte until the next frame.
module uart_rx #(
  parameter int UART_CLOCK_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_rx,
  output logic       done_rx
);
  localparam int TW = $clog2(UART_CLOCK_BIT);
  localparam logic [TW-1:0] FULL = TW'(UART_CLOCK_BIT - 1);
  localparam logic [TW-1:0] HALF = TW'(UART_CLOCK_BIT / 2 - 1);

  logic          rx_meta, rx_s, active;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] bit_timer;
  logic [7:0]    shift;

  // Synchronise the line, then sample mid-bit: start check, 8 data bits, stop bit
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      active    <= 1'b0;
      bit_cnt   <= 4'd0;
      bit_timer <= '0;
      shift     <= 8'h00;
      data_rx   <= 8'h00;
      done_rx   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      done_rx <= 1'b0;
      if (!active) begin
        if (!rx_s) begin
          active    <= 1'b1;
          bit_cnt   <= 4'd0;
          bit_timer <= HALF;
        end
      end else if (bit_timer != '0) begin
        bit_timer <= bit_timer - TW'(1);
      end else begin
        bit_timer <= FULL;
        if (bit_cnt == 4'd0) begin
          if (rx_s) active <= 1'b0;
          else      bit_cnt <= 4'd1;
        end else if (bit_cnt <= 4'd8) begin
          shift   <= {rx_s, shift[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else begin
          active <= 1'b0;
          if (rx_s) begin
            data_rx <= shift;
            done_rx <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first. Starts a frame on a one-cycle enable_tx
// while idle; done_tx pulses for one cycle once the stop bit has completed.
module uart_tx #(
  parameter int UART_CLOCK_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable_tx,
  input  logic [7:0] data_tx,
  output logic       tx,
  output logic       done_tx
);
  localparam int TW = $clog2(UART_CLOCK_BIT);
  localparam logic [TW-1:0] FULL = TW'(UART_CLOCK_BIT - 1);

  logic          active;
  logic [3:0]    bits_left;
  logic [TW-1:0] bit_timer;
  logic [8:0]    shift;

  // Bit timer counts down to zero; each terminal count moves to the next bit
  always_ff @(posedge clock) begin
    if (reset) begin
      tx        <= 1'b1;
      done_tx   <= 1'b0;
      active    <= 1'b0;
      bits_left <= 4'd0;
      bit_timer <= '0;
      shift     <= '1;
    end else begin
      done_tx <= 1'b0;
      if (!active) begin
        if (enable_tx) begin
          active    <= 1'b1;
          tx        <= 1'b0;
          shift     <= {1'b1, data_tx};
          bits_left <= 4'd9;
          bit_timer <= FULL;
        end
      end else if (bit_timer != '0) begin
        bit_timer <= bit_timer - TW'(1);
      end else if (bits_left == 4'd0) begin
        active  <= 1'b0;
        done_tx <= 1'b1;
      end else begin
        tx        <= shift[0];
        shift     <= {1'b1, shift[8:1]};
        bits_left <= bits_left - 4'd1;
        bit_timer <= FULL;
      end
    end
  end
endmodule

// File: rtl/sensor_node_responder.sv
// Sensor node responder on the half-duplex UART sensor bus. Answers a READ
// request addressed to NODE_ADDR with the snapshot byte followed by its CRC-8,
// driving the line only while responding.
// Optional macro SENSOR_NODE_GUARD_EN: holds the line idle-high for
// GUARD_BITS bit-times before the data byte.
//
// state     | meaning
// IDLE      | waiting for a received request byte
// CHECK     | decode command/address, capture data byte and CRC
// GUARD     | line driven high for the guard time (macro build only)
// SEND_DATA | one-cycle start strobe for the data byte
// WAIT_DATA | data byte shifting out
// SEND_CRC  | one-cycle start strobe for the CRC byte
// WAIT_CRC  | CRC byte shifting out
// DONE      | release line, pulse resp_done
module sensor_node_responder
  import sensor_bus_pkg::*;
#(
  parameter int         UART_CLOCK_BIT = 434,
  parameter logic [2:0] NODE_ADDR      = 3'd1,
  parameter int         GUARD_BITS     = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  sensor_node_responder_if.slave        bus,
  input  logic [7:0]                    sensor_data,
  input  logic                          sensor_valid,
  output logic                          busy,
  output logic                          resp_done
);
  resp_state_t state;
  logic [7:0]  snapshot, snapshot_crc, req_byte, data_tx, crc_byte, data_rx;
  logic        done_rx, done_tx, enable_tx, line_tx, tx_oe_r, frozen;

`ifdef SENSOR_NODE_GUARD_EN
  localparam int GUARD_CYCLES = GUARD_BITS * UART_CLOCK_BIT;
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  logic [GW-1:0] guard_timer;
`endif

  uart_rx #(.UART_CLOCK_BIT(UART_CLOCK_BIT)) u_rx (
    .clock   (clock),
    .reset   (reset),
    .rx      (bus.rx),
    .data_rx (data_rx),
    .done_rx (done_rx)
  );

  uart_tx #(.UART_CLOCK_BIT(UART_CLOCK_BIT)) u_tx (
    .clock     (clock),
    .reset     (reset),
    .enable_tx (enable_tx),
    .data_tx   (data_tx),
    .tx        (line_tx),
    .done_tx   (done_tx)
  );

  crc8_gen u_crc (
    .data_in (snapshot),
    .crc_out (snapshot_crc)
  );

  // Line is released (idle-high) whenever the driver is not enabled
  assign bus.tx    = tx_oe_r ? line_tx : 1'b1;
  assign bus.tx_oe = tx_oe_r;

  // Snapshot is frozen while the response bytes are in flight
  assign frozen = (state == ST_SEND_DATA) || (state == ST_WAIT_DATA) ||
                  (state == ST_SEND_CRC)  || (state == ST_WAIT_CRC);

  // Sensor snapshot register
  always_ff @(posedge clock) begin
    if (reset)                       snapshot <= 8'h00;
    else if (sensor_valid && !frozen) snapshot <= sensor_data;
  end

  // Response FSM; data_tx doubles as the captured data byte, then carries the CRC
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      req_byte  <= 8'h00;
      data_tx   <= 8'h00;
      crc_byte  <= 8'h00;
      enable_tx <= 1'b0;
      tx_oe_r   <= 1'b0;
      busy      <= 1'b0;
      resp_done <= 1'b0;
`ifdef SENSOR_NODE_GUARD_EN
      guard_timer <= '0;
`endif
    end else begin
      enable_tx <= 1'b0;
      resp_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (done_rx) begin
            req_byte <= data_rx;
            busy     <= 1'b1;
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (req_byte[7:3] == CMD_READ && req_byte[2:0] == NODE_ADDR) begin
            data_tx  <= snapshot;
            crc_byte <= snapshot_crc;
            tx_oe_r  <= 1'b1;
`ifdef SENSOR_NODE_GUARD_EN
            guard_timer <= GW'(GUARD_CYCLES - 1);
            state       <= ST_GUARD;
`else
            enable_tx <= 1'b1;
            state     <= ST_SEND_DATA;
`endif
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
`ifdef SENSOR_NODE_GUARD_EN
        ST_GUARD: begin
          if (guard_timer == '0) begin
            enable_tx <= 1'b1;
            state     <= ST_SEND_DATA;
          end else begin
            guard_timer <= guard_timer - GW'(1);
          end
        end
`endif
        ST_SEND_DATA: state <= ST_WAIT_DATA;
        ST_WAIT_DATA: begin
          if (done_tx) begin
            data_tx   <= crc_byte;
            enable_tx <= 1'b1;
            state     <= ST_SEND_CRC;
          end
        end
        ST_SEND_CRC: state <= ST_WAIT_CRC;
        ST_WAIT_CRC: begin
          if (done_tx) begin
            tx_oe_r   <= 1'b0;
            resp_done <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          tx_oe_r <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sensor_node_responder.sv
// Directed bench for sensor_node_responder: a table of request/response
// vectors plus hand-written sequences for snapshot freeze, ignored requests
// during a response, and reset in the middle of a byte.
module tb_sensor_node_responder;
  localparam int UCB           = 16;
  localparam int GUARD_BITS_TB = 2;
`ifdef SENSOR_NODE_GUARD_EN
  localparam int EXP_START_DLY = 1 + GUARD_BITS_TB * UCB;
`else
  localparam int EXP_START_DLY = 1;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sensor_data = 8'h00;
  logic       sensor_valid = 1'b0;
  logic       busy, resp_done;

  sensor_node_responder_if bus_if ();

  sensor_node_responder #(
    .UART_CLOCK_BIT (UCB),
    .NODE_ADDR      (3'd1),
    .GUARD_BITS     (GUARD_BITS_TB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus_if),
    .sensor_data  (sensor_data),
    .sensor_valid (sensor_valid),
    .busy         (busy),
    .resp_done    (resp_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Line monitor state
  int         cyc = 0;
  int         done_cyc = -1, oe_rise_cyc = -1, start_dly = -1;
  int         oe_rises = 0, resp_cnt = 0, busy_cyc = 0;
  logic       oe_prev = 1'b0, start_pending = 1'b0;
  bit         dec_active = 1'b0;
  int         dec_t = 0, dec_bit = 0;
  logic [7:0] dec_sh = 8'h00;
  logic [7:0] byte_q[$];

  typedef struct {
    logic       sv;
    logic [7:0] sdata;
    logic [7:0] req;
    logic       resp;
    logic [7:0] exp_d;
    logic [7:0] exp_c;
  } vec_t;
  localparam int NV = 9;
  vec_t vec[NV];

  // Decode tx frames, time tx_oe against the received request, count pulses
  always @(negedge clock) begin
    cyc++;
    if (dut.done_rx) done_cyc = cyc;
    if (bus_if.tx_oe === 1'b1 && oe_prev !== 1'b1) begin
      oe_rise_cyc   = cyc;
      oe_rises++;
      start_pending = 1'b1;
    end
    oe_prev = bus_if.tx_oe;
    if (resp_done === 1'b1) resp_cnt++;
    if (busy === 1'b1) busy_cyc++;
    if (!dec_active) begin
      if (bus_if.tx === 1'b0) begin
        dec_active = 1'b1;
        dec_t      = UCB / 2;
        dec_bit    = 0;
        if (start_pending) begin
          start_dly     = cyc - oe_rise_cyc;
          start_pending = 1'b0;
        end
      end
    end else begin
      dec_t--;
      if (dec_t == 0) begin
        dec_t = UCB;
        if (dec_bit == 0) begin
          if (bus_if.tx === 1'b1) dec_active = 1'b0;
          else dec_bit = 1;
        end else if (dec_bit <= 8) begin
          dec_sh = {bus_if.tx, dec_sh[7:1]};
          dec_bit++;
        end else begin
          dec_active = 1'b0;
          byte_q.push_back(dec_sh);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    byte_q.delete();
    resp_cnt    = 0;
    busy_cyc    = 0;
    oe_rises    = 0;
    start_dly   = -1;
    done_cyc    = -1;
    oe_rise_cyc = -1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus_if.rx = fr[i];
      repeat (UCB) @(negedge clock);
    end
  endtask

  task automatic wait_resp(input string name);
    int k;
    k = 0;
    while (resp_cnt < 1 && k < 3000) begin
      @(negedge clock);
      k++;
    end
    check({name, " resp_done seen"}, 32'(resp_cnt >= 1), 32'd1);
  endtask

  task automatic wait_oe(input string name);
    int k;
    k = 0;
    while (bus_if.tx_oe !== 1'b1 && k < 1000) begin
      @(negedge clock);
      k++;
    end
    check({name, " tx_oe rise"}, 32'(bus_if.tx_oe), 32'd1);
  endtask

  task automatic check_pair(input string name, input logic [7:0] d, input logic [7:0] c);
    logic [7:0] b0, b1;
    b0 = (byte_q.size() > 0) ? byte_q[0] : 8'hxx;
    b1 = (byte_q.size() > 1) ? byte_q[1] : 8'hxx;
    check({name, " byte count"}, 32'(byte_q.size()), 32'd2);
    check({name, " data byte"}, 32'(b0), 32'(d));
    check({name, " crc byte"}, 32'(b1), 32'(c));
    check({name, " resp_done pulses"}, 32'(resp_cnt), 32'd1);
  endtask

  initial begin
    vec[0] = '{1'b1, 8'hA5, 8'h09, 1'b1, 8'hA5, 8'h72};
    vec[1] = '{1'b0, 8'h00, 8'h0A, 1'b0, 8'h00, 8'h00};
    vec[2] = '{1'b0, 8'h00, 8'h11, 1'b0, 8'h00, 8'h00};
    vec[3] = '{1'b1, 8'hFF, 8'h09, 1'b1, 8'hFF, 8'hF3};
    vec[4] = '{1'b1, 8'h00, 8'h09, 1'b1, 8'h00, 8'h00};
    vec[5] = '{1'b1, 8'h3C, 8'h0B, 1'b0, 8'h00, 8'h00};
    vec[6] = '{1'b0, 8'h00, 8'h09, 1'b1, 8'h3C, 8'hB4};
    vec[7] = '{1'b1, 8'h01, 8'h01, 1'b0, 8'h00, 8'h00};
    vec[8] = '{1'b1, 8'h01, 8'h09, 1'b1, 8'h01, 8'h07};

    bus_if.rx = 1'b1;
    reset = 1'b1;
    repeat (4) @(negedge clock);
    check("reset tx", 32'(bus_if.tx), 32'd1);
    check("reset tx_oe", 32'(bus_if.tx_oe), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset resp_done", 32'(resp_done), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    for (int i = 0; i < NV; i++) begin
      string nm;
      nm = $sformatf("row%0d", i);
      clear_mon();
      if (vec[i].sv) begin
        sensor_data  = vec[i].sdata;
        sensor_valid = 1'b1;
        @(negedge clock);
        sensor_valid = 1'b0;
      end
      send_rx(vec[i].req);
      if (vec[i].resp) begin
        wait_resp(nm);
        repeat (20) @(negedge clock);
        check_pair(nm, vec[i].exp_d, vec[i].exp_c);
        check({nm, " oe latency"}, 32'(oe_rise_cyc - done_cyc), 32'd2);
        check({nm, " start delay"}, 32'(start_dly), 32'(EXP_START_DLY));
      end else begin
        repeat (40) @(negedge clock);
        check({nm, " no resp_done"}, 32'(resp_cnt), 32'd0);
        check({nm, " no tx_oe"}, 32'(oe_rises), 32'd0);
        check({nm, " busy cycles"}, 32'(busy_cyc), 32'd1);
        check({nm, " no frames"}, 32'(byte_q.size()), 32'd0);
      end
      check({nm, " end tx_oe"}, 32'(bus_if.tx_oe), 32'd0);
      check({nm, " end tx"}, 32'(bus_if.tx), 32'd1);
      check({nm, " end busy"}, 32'(busy), 32'd0);
    end

    // New sample arriving mid-response must not corrupt the bytes in flight
    clear_mon();
    sensor_data  = 8'h01;
    sensor_valid = 1'b1;
    @(negedge clock);
    sensor_valid = 1'b0;
    send_rx(8'h09);
    wait_oe("freeze");
    repeat (10) @(negedge clock);
    sensor_data  = 8'h3C;
    sensor_valid = 1'b1;
    wait_resp("freeze");
    repeat (5) @(negedge clock);
    sensor_valid = 1'b0;
    repeat (20) @(negedge clock);
    check_pair("freeze", 8'h01, 8'h07);
    clear_mon();
    send_rx(8'h09);
    wait_resp("after freeze");
    repeat (20) @(negedge clock);
    check_pair("after freeze", 8'h3C, 8'hB4);

    // Second request landing during WAIT_CRC is ignored
    clear_mon();
    send_rx(8'h09);
    begin
      int k;
      k = 0;
      while (byte_q.size() < 1 && k < 1000) begin @(negedge clock); k++; end
      check("overlap first byte", 32'(byte_q.size()), 32'd1);
      k = 0;
      while (bus_if.tx !== 1'b0 && k < 100) begin @(negedge clock); k++; end
      check("overlap crc start", 32'(bus_if.tx), 32'd0);
    end
    send_rx(8'h09);
    wait_resp("overlap");
    repeat (400) @(negedge clock);
    check_pair("overlap", 8'h3C, 8'hB4);
    check("overlap single oe", 32'(oe_rises), 32'd1);
    check("overlap idle busy", 32'(busy), 32'd0);

    // Reset in the middle of the data byte
    clear_mon();
    send_rx(8'h09);
    wait_oe("midreset");
    repeat (40) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midreset tx", 32'(bus_if.tx), 32'd1);
    check("midreset tx_oe", 32'(bus_if.tx_oe), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (250) @(negedge clock);
    clear_mon();
    send_rx(8'h09);
    wait_resp("post reset");
    repeat (20) @(negedge clock);
    check_pair("post reset", 8'h00, 8'h00);
    check("post reset oe latency", 32'(oe_rise_cyc - done_cyc), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
